sprite_rom_arbiter: RTL and testbench
=====================================

# sprite_rom_arbiter

Shares one single-port sprite ROM among `N_REQ` sprite renderers (fruit, blade trail, score digits) in the VGA pixel pipeline. Requesters issue ROM read addresses with a valid/ready handshake. Per-cycle round-robin arbitration grants one requester, drives the ROM address, and tracks each read through the fixed ROM latency. Read data returns to the granting requester with a one-hot response strobe.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `ADDR_W`, 19, ROM address width
- `DATA_W`, 8, ROM word (palette index) width
- `ROM_LAT`, 1, ROM read latency in `vga_clk` cycles (1..3)

Ports:
- `vga_clk`  in  1  clock, all logic on posedge
- `reset_n`  in  1  asynchronous, active-low reset
- `frame_start`  in  1  one-cycle pulse at start of frame; resets round-robin pointer
- `req_valid`  in  N_REQ  per-requester read request
- `req_addr`  in  N_REQ*ADDR_W  flattened addresses; requester i at bits [i*ADDR_W +: ADDR_W]
- `req_ready`  out  N_REQ  one-hot grant, combinational from `req_valid` and pointer
- `rom_address`  out  ADDR_W  registered ROM address
- `rom_en`  out  1  registered ROM read enable
- `rom_q`  in  DATA_W  ROM data, valid `ROM_LAT` cycles after address presented
- `rsp_valid`  out  N_REQ  registered one-hot response strobe
- `rsp_data`  out  DATA_W  registered read data
- `busy`  out  1  any read in flight (OR of tag pipeline)

## Operation
- Pointer `ptr` (clog2(N_REQ) bits) marks the highest-priority requester.
- Grant: the first i with `req_valid[i]=1`, searching `ptr, ptr+1, … ` mod N_REQ.
  - `req_ready` is one-hot on that i.
  - All zero when no request is valid.
  - `req_ready` never depends on `req_ready` itself; there is no combinational loop.
- Accept: `req_valid[g] & req_ready[g]` sampled at posedge.
  - On that edge: `rom_address <= req_addr[g]`, `rom_en <= 1`, `ptr <= (g+1) mod N_REQ`.
  - One-hot tag of g enters the tag delay line.
- No accept: `rom_en <= 0`. `rom_address` holds its last value.
- `frame_start=1` at an edge forces `ptr <= 0`, overriding the accept update. The accept itself still proceeds, and in-flight reads complete.
- Tag delay line has depth `ROM_LAT+1`. At the tag's exit edge: `rsp_valid <= tag`, `rsp_data <= rom_q`.
  - With no tag exiting: `rsp_valid <= 0` and `rsp_data` holds.
- No response backpressure: requesters must consume `rsp_valid` on the cycle it is high.
- Throughput: one read per cycle sustained. Back-to-back accepts to different requesters return in order.
- A requester holding `req_valid` with a changing address is legal. The address sampled at the accept edge is used.
- Reset (async, any time):
  - `ptr=0`, `rom_address=0`, `rom_en=0`, `rsp_valid=0`, `rsp_data=0`, tag line cleared.
  - In-flight reads are dropped; no response is ever produced for them.
  - On release, outputs stay at reset values until the first accept.

## Timing
- Accept at edge E0. `rom_address`/`rom_en` are valid from E0 to E1.
- `rom_q` is valid after E(ROM_LAT). `rsp_valid`/`rsp_data` are high from E(ROM_LAT+1) to E(ROM_LAT+2).
- Request-to-response latency is `ROM_LAT+1` cycles, fixed and independent of load.
- Fairness: a continuously valid requester is granted within N_REQ cycles.
- Simultaneous `frame_start` and accept: the grant uses the pre-update `ptr`, and the next `ptr` is 0.
- `ptr` wraps from N_REQ-1 to 0.
- `N_REQ` not a power of two: the pointer is never loaded with values ≥ N_REQ.

## Structure
- Package `sprite_pkg` holds:
  - default `ADDR_W`, `DATA_W`, `ROM_LAT`
  - `SPRITE_N_REQ`
  - typedef `sprite_addr_t`
  - typedef `palette_idx_t`
- Sub-module `rr_pick`: purely combinational. Inputs are `req` (N_REQ) and `ptr`. Outputs are one-hot `grant` and binary `grant_idx`.
- Top level holds the pointer, address/enable registers, tag shift register and response registers.

## Test plan
- Reset, N_REQ=4, ROM_LAT=1: hold `reset_n=0` with `req_valid=4'b1111`.
  - All outputs stay 0 while in reset.
  - Release, then first accept grants requester 0 (`req_ready=4'b0001`).
- Single request: `req_valid=4'b0100`, `req_addr[2]=19'h12345`, ROM model returns addr[7:0].
  - `rom_address=19'h12345` one cycle later.
  - `rsp_valid=4'b0100` and `rsp_data=8'h45` exactly 2 cycles after accept.
- All four valid for 8 cycles: grant sequence 0,1,2,3,0,1,2,3.
  - `rsp_valid` follows the same order, delayed 2 cycles, one response per cycle.
- Pointer at 2 with `req_valid=4'b0011`: grant goes to 0, then `ptr=1`.
- `frame_start` together with an accept to requester 3: the accept completes and the response arrives.
  - Next grant with all valid goes to requester 0.
- Reset asserted one cycle after an accept: no `rsp_valid` ever appears for that read.
  - After release, a new request returns normally.

Source files
------------

// File: rtl/sprite_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sprite_pkg : shared widths, defaults and helpers for the sprite ROM arbiter
// Revision   : 1.0
// ---------------------------------------------------------------------------
package sprite_pkg;

  localparam int SPRITE_N_REQ   = 4;
  localparam int SPRITE_ADDR_W  = 19;
  localparam int SPRITE_DATA_W  = 8;
  localparam int SPRITE_ROM_LAT = 1;

  typedef logic [SPRITE_ADDR_W-1:0] sprite_addr_t;
  typedef logic [SPRITE_DATA_W-1:0] palette_idx_t;

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_rom_arbiter_rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_pick  : combinational round-robin picker, first valid at or after ptr
// Revision : 1.0
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] grant_idx
);

  logic           found;
  logic [PTR_W:0] pos;

  // One extra bit on pos so ptr+off can exceed N_REQ-1 before wrapping.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    for (int off = 0; off < N_REQ; off++) begin
      pos = {1'b0, ptr} + (PTR_W+1)'(off);
      if (pos >= (PTR_W+1)'(N_REQ)) begin
        pos = pos - (PTR_W+1)'(N_REQ);
      end
      if (!found && req[pos[PTR_W-1:0]]) begin
        found                  = 1'b1;
        grant[pos[PTR_W-1:0]]  = 1'b1;
        grant_idx              = pos[PTR_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sprite_rom_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sprite_rom_arbiter : round-robin sharing of one sprite ROM among renderers
// Revision           : 1.0
// ---------------------------------------------------------------------------
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int N_REQ   = SPRITE_N_REQ,
  parameter int ADDR_W  = SPRITE_ADDR_W,
  parameter int DATA_W  = SPRITE_DATA_W,
  parameter int ROM_LAT = SPRITE_ROM_LAT
) (
  input  logic                    vga_clk,
  input  logic                    reset_n,
  input  logic                    frame_start,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]       rom_address,
  output logic                    rom_en,
  input  logic [DATA_W-1:0]       rom_q,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    busy
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]             ptr;
  logic [PTR_W-1:0]             ptr_next;
  logic [PTR_W-1:0]             grant_idx;
  logic [N_REQ-1:0]             grant;
  logic                         accept;
  logic [ROM_LAT:0][N_REQ-1:0]  tag_line;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);
  assign ptr_next  = PTR_W'(wrap_inc(32'(grant_idx), N_REQ));
  assign busy      = |tag_line;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr         <= '0;
      rom_address <= '0;
      rom_en      <= 1'b0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      tag_line    <= '0;
    end else begin
      // frame_start wins over the accept's pointer advance, never the accept.
      if (frame_start) begin
        ptr <= '0;
      end else if (accept) begin
        ptr <= ptr_next;
      end

      rom_en <= accept;
      if (accept) begin
        rom_address <= req_addr[32'(grant_idx)*ADDR_W +: ADDR_W];
      end

      tag_line[0] <= accept ? grant : '0;
      for (int i = 1; i <= ROM_LAT; i++) begin
        tag_line[i] <= tag_line[i-1];
      end

      rsp_valid <= tag_line[ROM_LAT];
      if (|tag_line[ROM_LAT]) begin
        rsp_data <= rom_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sprite_rom_arbiter : directed stimulus with response scoreboard
// Revision              : 1.0
// ---------------------------------------------------------------------------
module tb_sprite_rom_arbiter;
  import sprite_pkg::*;

  localparam int N = 4;
  localparam int AW = 19;
  localparam int DW = 8;

  logic              vga_clk;
  logic              reset_n;
  logic              frame_start;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N-1:0]      req_ready;
  logic [AW-1:0]     rom_address;
  logic              rom_en;
  logic [DW-1:0]     rom_q;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              busy;

  sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .rom_address (rom_address),
    .rom_en      (rom_en),
    .rom_q       (rom_q),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .busy        (busy)
  );

  typedef struct {
    logic [N-1:0]  v;
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  exp_t         sb[$];
  sprite_addr_t addr[N];
  int           cyc;
  int           n_checks;
  int           n_fail;

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) cyc <= cyc + 1;

  // One-cycle ROM returning the low address byte.
  always @(posedge vga_clk) rom_q <= rom_address[7:0];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge vga_clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      check("rsp_valid", 32'(rsp_valid), 32'(e.v));
      check("rsp_data", 32'(rsp_data), 32'(e.d));
    end else begin
      check("rsp_idle", 32'(rsp_valid), 32'h0);
    end
  end

  task automatic apply(input logic [N-1:0] v, input logic fs, input logic [N-1:0] exp_rdy,
                       input logic [DW-1:0] exp_d, input bit push);
    req_valid   = v;
    frame_start = fs;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addr[i];
    #1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (push) sb.push_back('{exp_rdy, exp_d, cyc + 3});
  endtask

  task automatic step(input logic [N-1:0] v, input logic fs, input logic [N-1:0] exp_rdy,
                      input logic [DW-1:0] exp_d, input bit push);
    @(negedge vga_clk);
    apply(v, fs, exp_rdy, exp_d, push);
  endtask

  task automatic check_idle();
    check("rom_en_rst", 32'(rom_en), 32'h0);
    check("rom_addr_rst", 32'(rom_address), 32'h0);
    check("rsp_valid_rst", 32'(rsp_valid), 32'h0);
    check("rsp_data_rst", 32'(rsp_data), 32'h0);
    check("busy_rst", 32'(busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] exp_seq[8];

  initial begin
    cyc = 0; n_checks = 0; n_fail = 0;
    addr[0] = 19'h00011; addr[1] = 19'h10022; addr[2] = 19'h12345; addr[3] = 19'h7FF33;
    frame_start = 1'b0;
    req_valid   = 4'b1111;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addr[i];
    reset_n = 1'b1;
    #2 reset_n = 1'b0;

    // Held in reset with all requests valid: nothing moves.
    repeat (3) begin
      @(negedge vga_clk);
      #1 check_idle();
    end
    @(negedge vga_clk);
    reset_n = 1'b1;
    apply(4'b1111, 1'b0, 4'b0001, 8'h11, 1'b1);           // ptr -> 1

    step(4'b0100, 1'b0, 4'b0100, 8'h45, 1'b1);            // ptr -> 3
    @(posedge vga_clk);
    #1;
    check("rom_address", 32'(rom_address), 32'h12345);
    check("rom_en", 32'(rom_en), 32'h1);
    check("busy", 32'(busy), 32'h1);

    step(4'b0000, 1'b1, 4'b0000, 8'h00, 1'b0);            // ptr -> 0
    @(posedge vga_clk);
    #1 check("rom_en_idle", 32'(rom_en), 32'h0);

    exp_seq = '{8'h11, 8'h22, 8'h45, 8'h33, 8'h5C, 8'h22, 8'h45, 8'h33};
    for (int i = 0; i < 8; i++) begin
      if (i == 4) addr[0] = 19'h0AB5C;
      step(4'b1111, 1'b0, 4'(1 << (i % 4)), exp_seq[i], 1'b1);
    end

    step(4'b0010, 1'b0, 4'b0010, 8'h22, 1'b1);            // ptr -> 2
    step(4'b0011, 1'b0, 4'b0001, 8'h5C, 1'b1);            // wraps, ptr -> 1
    step(4'b0011, 1'b0, 4'b0010, 8'h22, 1'b1);            // ptr -> 2

    step(4'b1000, 1'b1, 4'b1000, 8'h33, 1'b1);            // frame_start + accept 3
    step(4'b0010, 1'b1, 4'b0010, 8'h22, 1'b1);            // forced to 0, not 2
    step(4'b1111, 1'b0, 4'b0001, 8'h5C, 1'b1);
    step(4'b1111, 1'b0, 4'b0010, 8'h22, 1'b1);            // ptr -> 2
    step(4'b0000, 1'b0, 4'b0000, 8'h00, 1'b0);

    // Accepted read dropped by reset before its response.
    step(4'b0100, 1'b0, 4'b0100, 8'h45, 1'b0);
    @(negedge vga_clk);
    req_valid = 4'b0000;
    reset_n   = 1'b0;
    #1 check_idle();
    repeat (2) begin
      @(negedge vga_clk);
      #1 check_idle();
    end
    @(negedge vga_clk);
    reset_n = 1'b1;
    step(4'b1100, 1'b0, 4'b0100, 8'h45, 1'b1);            // ptr restarted at 0
    step(4'b0000, 1'b0, 4'b0000, 8'h00, 1'b0);

    repeat (6) @(negedge vga_clk);
    #1 check("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
